// File: rtl/fpu_add_ctrl.sv
// fpu_add_ctrl: FADD/FSUB sequencing, special-case override and fflags around a combinational adder
module fpu_add_ctrl #(
  parameter int TAG_W = 5,
  parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      adder_a,
  output logic [31:0]      adder_b,
  input  logic [31:0]      adder_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic [4:0]       out_flags
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, nxt;
  logic [31:0] a_q, b_q, spec_res, spec_res_q, calc_res, bp, fa, fb;
  logic [TAG_W-1:0] tag_q;
  logic [4:0] spec_flags, spec_flags_q, calc_flags;
  logic spec_hit, spec_hit_q, accept;
  logic nan_a, nan_b, snan_a, snan_b, inf_a, inf_b, zero_a, zero_b, inf_cancel;
  assign bp = {in_b[31] ^ in_op, in_b[30:0]};
  // denormals become signed zeros before classification
  assign fa = ~|in_a[30:23] ? {in_a[31], 31'h0} : in_a;
  assign fb = ~|bp[30:23] ? {bp[31], 31'h0} : bp;
  assign nan_a = &fa[30:23] & |fa[22:0];
  assign nan_b = &fb[30:23] & |fb[22:0];
  assign snan_a = nan_a & ~fa[22];
  assign snan_b = nan_b & ~fb[22];
  assign inf_a = &fa[30:23] & ~|fa[22:0];
  assign inf_b = &fb[30:23] & ~|fb[22:0];
  assign zero_a = ~|fa[30:0];
  assign zero_b = ~|fb[30:0];
  assign inf_cancel = inf_a & inf_b & (fa[31] ^ fb[31]);
  always_comb begin
    spec_hit = nan_a | nan_b | inf_a | inf_b | zero_a | zero_b | ((fa[30:0] == fb[30:0]) & (fa[31] ^ fb[31]));
    spec_res = (nan_a | nan_b | inf_cancel) ? CANON_NAN :
               inf_a ? fa : inf_b ? fb :
               (zero_a & zero_b) ? {fa[31] & fb[31], 31'h0} :
               zero_a ? fb : zero_b ? fa : 32'h0;
    spec_flags = {(nan_a | nan_b) ? (snan_a | snan_b) : inf_cancel, 4'b0000};
  end
  always_comb begin
    calc_res = spec_hit_q ? spec_res_q :
               &adder_result[30:23] ? {adder_result[31], 8'hFF, 23'h0} :
               ~|adder_result[30:23] ? {adder_result[31], 31'h0} : adder_result;
    calc_flags = spec_hit_q ? spec_flags_q :
                 &adder_result[30:23] ? 5'b00101 :
                 ~|adder_result[30:23] ? 5'b00011 : 5'b00000;
  end
  assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
  assign accept = in_valid & in_ready & ~flush;
  assign out_valid = state == DONE;
  assign adder_a = a_q;
  assign adder_b = b_q;
  always_comb begin
    nxt = state;
    nxt = flush ? IDLE :
          (state == IDLE) ? (in_valid ? CALC : IDLE) :
          (state == CALC) ? DONE :
          out_ready ? (in_valid ? CALC : IDLE) : DONE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      a_q <= '0;
      b_q <= '0;
      tag_q <= '0;
      spec_hit_q <= 1'b0;
      spec_res_q <= '0;
      spec_flags_q <= '0;
      out_result <= '0;
      out_tag <= '0;
      out_flags <= '0;
    end else begin
      state <= nxt;
      if (accept) begin
        a_q <= in_a;
        b_q <= bp;
        tag_q <= in_tag;
        spec_hit_q <= spec_hit;
        spec_res_q <= spec_res;
        spec_flags_q <= spec_flags;
      end
      if (state == CALC && !flush) begin
        out_result <= calc_res;
        out_tag <= tag_q;
        out_flags <= calc_flags;
      end
    end
  end
endmodule

// File: tb/tb_fpu_add_ctrl.sv
// tb_fpu_add_ctrl: directed vectors with hand-computed results; the bench plays the adder
module tb_fpu_add_ctrl;
  logic clk = 0, reset = 1, flush = 0, in_valid = 0, in_op = 0, out_ready = 1;
  logic [31:0] in_a = 0, in_b = 0, adder_result = 0;
  logic [4:0] in_tag = 0;
  logic in_ready, out_valid;
  logic [31:0] adder_a, adder_b, out_result;
  logic [4:0] out_tag, out_flags;
  int checks = 0, errors = 0;

  fpu_add_ctrl dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_tag(in_tag), .adder_a(adder_a),
    .adder_b(adder_b), .adder_result(adder_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag), .out_flags(out_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic op,
                       input logic [4:0] tag, input logic [31:0] av);
    in_valid = 1; in_a = a; in_b = b; in_op = op; in_tag = tag; adder_result = av;
  endtask

  task automatic run(input string name, input logic [31:0] a, input logic [31:0] b,
                     input logic op, input logic [4:0] tag, input logic [31:0] av,
                     input logic [31:0] er, input logic [4:0] ef);
    @(negedge clk);
    drive(a, b, op, tag, av);
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk({name, "_calc_valid"}, out_valid, 0);
    chk({name, "_calc_ready"}, in_ready, 0);
    @(negedge clk);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_result"}, out_result, er);
    chk({name, "_tag"}, out_tag, tag);
    chk({name, "_flags"}, out_flags, ef);
  endtask

  initial begin
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_result", out_result, 0);
    chk("rst_adder_a", adder_a, 0);
    @(negedge clk); reset = 0;
    #1 chk("rst_ready", in_ready, 1);

    run("add12", 32'h3F800000, 32'h40000000, 0, 7, 32'h40400000, 32'h40400000, 5'b00000);
    chk("opnd_b", adder_b, 32'h40000000);
    run("infsub", 32'h7F800000, 32'h7F800000, 1, 1, 32'h12345678, 32'h7FC00000, 5'b10000);
    run("nzero", 32'h80000000, 32'h80000000, 0, 2, 32'h12345678, 32'h80000000, 5'b00000);
    run("mzero", 32'h00000000, 32'h80000000, 0, 3, 32'h12345678, 32'h00000000, 5'b00000);
    run("cancel", 32'h40400000, 32'h40400000, 1, 4, 32'h12345678, 32'h00000000, 5'b00000);
    chk("sub_flip", adder_b, 32'hC0400000);
    run("ovf", 32'h7F7FFFFF, 32'h7F7FFFFF, 0, 5, 32'h7F800000, 32'h7F800000, 5'b00101);
    run("ovf_neg", 32'h3F800000, 32'h40000000, 0, 6, 32'hFFC00001, 32'hFF800000, 5'b00101);
    run("unf", 32'h00800001, 32'h00800000, 1, 8, 32'h80000800, 32'h80000000, 5'b00011);
    run("snan", 32'h7F800001, 32'h3F800000, 0, 9, 32'h12345678, 32'h7FC00000, 5'b10000);
    run("qnan", 32'h7FC00001, 32'h3F800000, 0, 10, 32'h12345678, 32'h7FC00000, 5'b00000);
    run("denorm", 32'h00000001, 32'h40000000, 0, 11, 32'h12345678, 32'h40000000, 5'b00000);
    run("zsub", 32'h00000000, 32'h3F800000, 1, 12, 32'h12345678, 32'hBF800000, 5'b00000);
    run("inf1", 32'h3F800000, 32'h7F800000, 0, 13, 32'h12345678, 32'h7F800000, 5'b00000);
    run("infinf", 32'hFF800000, 32'h7F800000, 1, 14, 32'h12345678, 32'hFF800000, 5'b00000);

    // backpressure: result must hold while a competing request waits
    @(negedge clk);
    out_ready = 0;
    drive(32'h3F800000, 32'h40000000, 0, 3, 32'h40400000);
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    drive(32'h40400000, 32'h3F800000, 0, 20, 32'h40800000);
    for (int i = 0; i < 3; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_result", out_result, 32'h40400000);
      chk("bp_tag", out_tag, 3);
      chk("bp_ready", in_ready, 0);
      @(negedge clk);
    end
    drive(32'h3F800000, 32'h3F800000, 0, 9, 32'h40000000);
    out_ready = 1;
    #1 chk("b2b_ready", in_ready, 1);
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    chk("b2b_calc", out_valid, 0);
    @(negedge clk);
    chk("b2b_valid", out_valid, 1);
    chk("b2b_result", out_result, 32'h40000000);
    chk("b2b_tag", out_tag, 9);

    // flush while calculating
    @(negedge clk);
    drive(32'h3F800000, 32'h40000000, 0, 15, 32'h40400000);
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk); flush = 1;
    @(posedge clk); #1 flush = 0;
    @(negedge clk);
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    @(negedge clk);
    chk("fl_valid2", out_valid, 0);

    // flush beats a simultaneous accept
    drive(32'h3F800000, 32'h40000000, 0, 16, 32'h40400000);
    flush = 1;
    @(posedge clk); #1 begin flush = 0; in_valid = 0; end
    @(negedge clk);
    chk("fla_ready", in_ready, 1);
    @(negedge clk);
    chk("fla_valid", out_valid, 0);

    // asynchronous reset while a result is on offer
    out_ready = 0;
    drive(32'h3F800000, 32'h40000000, 0, 17, 32'h40400000);
    @(posedge clk); #1 in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rd_valid", out_valid, 1);
    #2 reset = 1;
    #1;
    chk("ra_valid", out_valid, 0);
    chk("ra_result", out_result, 0);
    chk("ra_tag", out_tag, 0);
    chk("ra_flags", out_flags, 0);
    chk("ra_adder_a", adder_a, 0);
    @(negedge clk); reset = 0; out_ready = 1;
    #1 chk("ra_ready", in_ready, 1);
    @(negedge clk);
    chk("ra_valid2", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got running expected done");
    $fatal(1);
  end
endmodule

// File: doc/fpu_add_ctrl.md
Name: fpu_add_ctrl

Overview:
- Sequencing and special-case stage around the combinational single-precision adder (fpu_adder) in the FPU execute path.
- Accepts FADD.S/FSUB.S requests from issue over a valid/ready handshake, applies the subtract sign flip, registers operands and drives them to the adder.
- Classifies NaN/Inf/zero/denormal, overrides the adder result where the adder datapath is not valid, and returns the result with RISC-V fflags to writeback over a second valid/ready handshake. Fixed 2-cycle latency.

Parameters:
- TAG_W, 5, width of the destination tag carried alongside the operation.
- CANON_NAN, 32'h7FC00000, canonical quiet NaN returned for all NaN results.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  synchronous kill of any in-flight operation (pipeline flush).
- in_valid  input  1  request valid.
- in_ready  output  1  stage can accept a request this cycle.
- in_op  input  1  0 = add, 1 = subtract (a - b).
- in_a  input  32  operand a, IEEE-754 single.
- in_b  input  32  operand b, IEEE-754 single.
- in_tag  input  TAG_W  destination tag.
- adder_a  output  32  operand to adder number1.
- adder_b  output  32  operand to adder number2.
- adder_result  input  32  adder combinational output.
- out_valid  output  1  result valid.
- out_ready  input  1  writeback accepts the result.
- out_result  output  32  final result.
- out_tag  output  TAG_W  tag of the result.
- out_flags  output  5  {NV,DZ,OF,UF,NX}.

Behaviour:
- Reset (asynchronous): state = IDLE; out_valid = 0; out_result = 0; out_tag = 0; out_flags = 0; operand registers = 0. in_ready = 1 after reset releases.
- FSM states:
  - IDLE: in_ready = 1. On accept (in_valid & in_ready), go to CALC.
  - CALC: exactly one cycle; in_ready = 0. On the clock edge, capture the final result/flags and go to DONE.
  - DONE: out_valid = 1; outputs held stable.
    - out_ready = 1 and in_valid = 1: accept the new request (in_ready = 1 in this case only) and go to CALC.
    - out_ready = 1 and in_valid = 0: go to IDLE.
    - out_ready = 0: stay in DONE with outputs unchanged.
- Latency: request accepted on edge N, out_valid high from cycle N+2. Back-to-back throughput is one result per 2 cycles.
- On accept, register:
  - a;
  - b' = {b[31]^in_op, b[30:0]};
  - tag;
  - a special-case record (spec_hit, spec_result, spec_flags) computed from a and b'.
- adder_a and adder_b are always driven from the operand registers, including for special cases.
- Classification (denormals flushed to signed zero before all checks; no flag raised for the flush):
  - Either operand NaN: CANON_NAN. NV = 1 if either is a signalling NaN (exp = FF, frac != 0, frac[22] = 0).
  - Inf + Inf with opposite signs: CANON_NAN, NV = 1.
  - Exactly one Inf, or two Inf of the same sign: that Inf.
  - Both zero: -0 if both signs are 1, else +0.
  - Exactly one zero: the other operand, unchanged.
  - Equal exponent and fraction with opposite signs: +0.
  - Otherwise spec_hit = 0.
- CALC capture:
  - spec_hit = 1: spec_result and spec_flags.
  - spec_hit = 0: take adder_result, with these overrides:
    - Exponent field FF: result is {sign,8'hFF,23'h0}, flags OF|NX.
    - Exponent field 00: result is {sign,31'h0}, flags UF|NX.
    - Otherwise: adder_result as-is, flags 0.
- DZ is always 0.
- flush: forces state to IDLE and out_valid to 0 on the next edge, in any state, with no result delivered. If flush and an accept occur in the same cycle, flush wins and the request is dropped.
- Reset during CALC or DONE: the operation is lost and no out_valid is produced.

Test Plan:
- 1.0 + 2.0: in_a = 0x3F800000, in_b = 0x40000000, op = 0, tag = 7, accepted at edge N -> out_valid at N+2, out_result = 0x40400000, out_tag = 7, flags = 5'b00000.
- Inf - Inf: a = b = 0x7F800000, op = 1 -> out_result = 0x7FC00000, flags = 5'b10000.
- Zero cases:
  - 0x80000000 + 0x80000000 -> 0x80000000.
  - 0x00000000 + 0x80000000 -> 0x00000000.
  - 3.0 - 3.0 (0x40400000 both, op = 1) -> 0x00000000, flags 0.
- Overflow: 0x7F7FFFFF + 0x7F7FFFFF with the adder returning exponent FF -> out_result = 0x7F800000, flags = 5'b00101.
- Backpressure and back-to-back:
  - Hold out_ready = 0 for 3 cycles -> out_valid, result and tag stable, in_ready = 0.
  - Raise out_ready with a new in_valid -> accepted the same cycle, next out_valid 2 cycles later.
- Flush/reset: assert flush in CALC -> out_valid never rises, in_ready = 1 next cycle. Assert reset asynchronously in DONE -> out_valid drops immediately, all outputs 0.
